// File: rtl/vx_mem_credit_arb_pkg.sv
// Shared types and width helpers for the credit-based memory arbiter.
// The request struct is sized for the largest supported build (DATA_WIDTH <= 1024, ADDR_WIDTH <= 64, tags <= 32 bits).
package VX_mem_arb_pkg;

  localparam int MAX_DATA_W = 1024;
  localparam int MAX_ADDR_W = 64;
  localparam int MAX_TAG_W  = 32;

  typedef struct packed {
    logic                    rw;
    logic [MAX_DATA_W/8-1:0] byteen;
    logic [MAX_ADDR_W-1:0]   addr;
    logic [MAX_DATA_W-1:0]   data;
    logic [MAX_TAG_W-1:0]    tag;
  } mem_req_t;

  function automatic int log_reqs(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Index signals need at least one bit even when there is a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tag_out_width(input int tag_in_w, input int n);
    return tag_in_w + log_reqs(n);
  endfunction

endpackage

// File: rtl/vx_mem_credit_arb_rr.sv
// Round-robin grant search: first eligible requester at or after the pointer, with wrap-around.
// The pointer moves to one past the granted index only when the grant is taken.
module VX_rr_arbiter
  import VX_mem_arb_pkg::*;
#(
  parameter int  NUM_REQS = 4,
  localparam int IDX_W    = idx_width(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] eligible_i,
  input  logic                advance_i,
  output logic [NUM_REQS-1:0] grant_oh_o,
  output logic [IDX_W-1:0]    grant_idx_o,
  output logic                grant_vld_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Scan from the far end so the closest eligible index to the pointer wins.
  always_comb begin : search
    int j;
    j           = 0;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQS) j = j - NUM_REQS;
      if (eligible_i[IDX_W'(j)]) begin
        grant_idx_o = IDX_W'(j);
        grant_vld_o = 1'b1;
      end
    end
    if (grant_vld_o) grant_oh_o[grant_idx_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && grant_vld_o)
      ptr_d = (int'(grant_idx_o) == NUM_REQS - 1) ? '0 : grant_idx_o + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vx_mem_credit_arb.sv
// Credit-limited round-robin arbiter merging NUM_REQS requesters onto one memory port, with response routing.
// Optional VX_MEM_ARB_PERF_EN adds 64-bit stall-cycle and accepted-read counters.
module vx_mem_credit_arb
  import VX_mem_arb_pkg::*;
#(
  parameter int  NUM_REQS      = 4,
  parameter int  DATA_WIDTH    = 512,
  parameter int  ADDR_WIDTH    = 26,
  parameter int  TAG_IN_WIDTH  = 8,
  parameter int  MAX_PENDING   = 16,
  localparam int LOG_REQS      = log_reqs(NUM_REQS),
  localparam int TAG_OUT_WIDTH = tag_out_width(TAG_IN_WIDTH, NUM_REQS)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_REQS-1:0]                      req_valid_in,
  input  logic [NUM_REQS-1:0]                      req_rw_in,
  input  logic [NUM_REQS-1:0][DATA_WIDTH/8-1:0]    req_byteen_in,
  input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]      req_addr_in,
  input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]      req_data_in,
  input  logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]    req_tag_in,
  output logic [NUM_REQS-1:0]                      req_ready_in,
  output logic                                     req_valid_out,
  output logic                                     req_rw_out,
  output logic [DATA_WIDTH/8-1:0]                  req_byteen_out,
  output logic [ADDR_WIDTH-1:0]                    req_addr_out,
  output logic [DATA_WIDTH-1:0]                    req_data_out,
  output logic [TAG_OUT_WIDTH-1:0]                 req_tag_out,
  input  logic                                     req_ready_out,
  input  logic                                     rsp_valid_in,
  input  logic [DATA_WIDTH-1:0]                    rsp_data_in,
  input  logic [TAG_OUT_WIDTH-1:0]                 rsp_tag_in,
  output logic                                     rsp_ready_in,
  output logic [NUM_REQS-1:0]                      rsp_valid_out,
  output logic [NUM_REQS-1:0][DATA_WIDTH-1:0]      rsp_data_out,
  output logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]    rsp_tag_out,
  input  logic [NUM_REQS-1:0]                      rsp_ready_out,
`ifdef VX_MEM_ARB_PERF_EN
  output logic [63:0]                              perf_stall_cycles,
  output logic [63:0]                              perf_reads,
`endif
  output logic                                     busy
);

  localparam int IDX_W  = idx_width(NUM_REQS);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  logic [NUM_REQS-1:0]              eligible;
  logic [NUM_REQS-1:0]              grant_oh;
  logic [IDX_W-1:0]                 gidx;
  logic                             grant_vld;
  logic                             out_ready, accept;
  logic [TAG_OUT_WIDTH-1:0]         tag_new;
  logic [IDX_W-1:0]                 rsp_idx;
  logic                             rsp_hit, rsp_fire;
  logic [NUM_REQS-1:0][PEND_W-1:0]  pend_q, pend_d;
  logic                             vld_q;
  mem_req_t                         req_q;
  logic                             unused_req_bits;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQS; i++)
      eligible[i] = req_valid_in[i] && (req_rw_in[i] || (pend_q[i] < PEND_W'(MAX_PENDING)));
  end

  VX_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .eligible_i  (eligible),
    .advance_i   (accept),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (gidx),
    .grant_vld_o (grant_vld)
  );

  assign out_ready    = !vld_q || req_ready_out;
  assign accept       = grant_vld && out_ready && !reset;
  assign req_ready_in = accept ? grant_oh : '0;

  if (LOG_REQS > 0) begin : g_tag_idx
    assign tag_new = {req_tag_in[gidx], gidx};
    assign rsp_idx = rsp_tag_in[LOG_REQS-1:0];
  end else begin : g_tag_single
    assign tag_new = req_tag_in[gidx];
    assign rsp_idx = '0;
  end

  // Output register: fields load only on accept, so they hold while the memory side stalls.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_q.rw     <= req_rw_in[gidx];
      req_q.byteen <= (MAX_DATA_W/8)'(req_byteen_in[gidx]);
      req_q.addr   <= MAX_ADDR_W'(req_addr_in[gidx]);
      req_q.data   <= MAX_DATA_W'(req_data_in[gidx]);
      req_q.tag    <= MAX_TAG_W'(tag_new);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          vld_q <= 1'b0;
    else if (out_ready) vld_q <= accept;
  end

  assign req_valid_out   = vld_q;
  assign req_rw_out      = req_q.rw;
  assign req_byteen_out  = (DATA_WIDTH/8)'(req_q.byteen);
  assign req_addr_out    = ADDR_WIDTH'(req_q.addr);
  assign req_data_out    = DATA_WIDTH'(req_q.data);
  assign req_tag_out     = TAG_OUT_WIDTH'(req_q.tag);
  assign unused_req_bits = ^req_q;

  // Response path is purely combinational; data fans out to every requester.
  assign rsp_hit      = int'(rsp_idx) < NUM_REQS;
  assign rsp_ready_in = rsp_hit && rsp_ready_out[rsp_idx];
  assign rsp_fire     = rsp_valid_in && rsp_ready_in;

  always_comb begin
    rsp_valid_out = '0;
    rsp_data_out  = '0;
    rsp_tag_out   = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      rsp_valid_out[i] = rsp_valid_in && (rsp_idx == IDX_W'(i));
      rsp_data_out[i]  = rsp_data_in;
      rsp_tag_out[i]   = TAG_IN_WIDTH'(rsp_tag_in >> LOG_REQS);
    end
  end

  // Credit counters: a same-cycle read accept and response on one requester cancel out.
  always_comb begin
    logic inc, dec;
    inc    = 1'b0;
    dec    = 1'b0;
    pend_d = pend_q;
    for (int i = 0; i < NUM_REQS; i++) begin
      inc = accept && !req_rw_in[gidx] && (gidx == IDX_W'(i));
      dec = rsp_fire && (rsp_idx == IDX_W'(i));
      if (inc && !dec)
        pend_d[i] = pend_q[i] + PEND_W'(1);
      else if (dec && !inc && (pend_q[i] != '0))
        pend_d[i] = pend_q[i] - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  always_ff @(posedge clk) begin
    if (!reset && rsp_fire && rsp_hit)
      assert (pend_q[rsp_idx] != '0);
  end

  assign busy = !reset && (vld_q || (|pend_q));

`ifdef VX_MEM_ARB_PERF_EN
  logic [63:0] stall_q, reads_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      reads_q <= '0;
    end else begin
      if ((|req_valid_in) && !accept) stall_q <= stall_q + 64'd1;
      if (accept && !req_rw_in[gidx]) reads_q <= reads_q + 64'd1;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_reads        = reads_q;
`endif

endmodule

// File: tb/tb_vx_mem_credit_arb.sv
// Directed bench for vx_mem_credit_arb (4 requesters, 32-bit data) with a request scoreboard and credit model.
module tb_vx_mem_credit_arb;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 26;
  localparam int TW  = 8;
  localparam int MP  = 16;
  localparam int TOW = TW + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]              req_valid_in, req_rw_in, req_ready_in;
  logic [N-1:0][DW/8-1:0]    req_byteen_in;
  logic [N-1:0][AW-1:0]      req_addr_in;
  logic [N-1:0][DW-1:0]      req_data_in;
  logic [N-1:0][TW-1:0]      req_tag_in;
  logic                      req_valid_out, req_rw_out, req_ready_out;
  logic [DW/8-1:0]           req_byteen_out;
  logic [AW-1:0]             req_addr_out;
  logic [DW-1:0]             req_data_out;
  logic [TOW-1:0]            req_tag_out;
  logic                      rsp_valid_in, rsp_ready_in;
  logic [DW-1:0]             rsp_data_in;
  logic [TOW-1:0]            rsp_tag_in;
  logic [N-1:0]              rsp_valid_out, rsp_ready_out;
  logic [N-1:0][DW-1:0]      rsp_data_out;
  logic [N-1:0][TW-1:0]      rsp_tag_out;
  logic                      busy;

  vx_mem_credit_arb #(
    .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_byteen_in(req_byteen_in),
    .req_addr_in(req_addr_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready_in(req_ready_in),
    .req_valid_out(req_valid_out), .req_rw_out(req_rw_out), .req_byteen_out(req_byteen_out),
    .req_addr_out(req_addr_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
    .req_ready_out(req_ready_out),
    .rsp_valid_in(rsp_valid_in), .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in),
    .rsp_ready_in(rsp_ready_in),
    .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out),
    .rsp_ready_out(rsp_ready_out),
    .busy(busy)
  );

  typedef struct packed {
    logic           rw;
    logic [DW/8-1:0] byteen;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [TOW-1:0] tag;
  } exp_t;

  exp_t       sbq[$];
  exp_t       snap;
  int         total = 0;
  int         bad   = 0;
  int         exp_pend[N];
  int         exp_ptr;
  bit         exp_vld;
  logic [N-1:0] obs_rin;
  int         last_g;
  int         n_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    int j;
    for (int k = 0; k < N; k++) begin
      j = (exp_ptr + k) % N;
      if (req_valid_in[j] && (req_rw_in[j] || exp_pend[j] < MP)) return j;
    end
    return -1;
  endfunction

  function automatic bit pend_any();
    for (int i = 0; i < N; i++) if (exp_pend[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) exp_pend[i] = 0;
    exp_ptr = 0;
    exp_vld = 1'b0;
    sbq.delete();
  endtask

  // One clock: fresh payloads, check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    int   g, ri;
    bit   acc, fire_out, rfire;
    exp_t e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      req_addr_in[i]   = AW'($urandom);
      req_data_in[i]   = $urandom;
      req_tag_in[i]    = TW'($urandom);
      req_byteen_in[i] = 4'($urandom);
    end
    #1;
    g      = model_grant();
    acc    = (g >= 0) && (!exp_vld || req_ready_out);
    obs_rin = req_ready_in;
    last_g = g;
    chk("req_ready_in", 64'(req_ready_in), acc ? (64'd1 << g) : 64'd0);
    ri    = int'(rsp_tag_in[1:0]);
    rfire = rsp_valid_in && rsp_ready_out[ri];
    chk("rsp_ready_in", 64'(rsp_ready_in), 64'(rsp_ready_out[ri]));
    chk("rsp_valid_out", 64'(rsp_valid_out), rsp_valid_in ? (64'd1 << ri) : 64'd0);
    fire_out = exp_vld && req_ready_out;
    if (acc) begin
      e.rw     = req_rw_in[g];
      e.byteen = req_byteen_in[g];
      e.addr   = req_addr_in[g];
      e.data   = req_data_in[g];
      e.tag    = {req_tag_in[g], 2'(g)};
    end
    @(posedge clk);
    if (fire_out) void'(sbq.pop_front());
    if (acc) begin
      sbq.push_back(e);
      if (!e.rw) exp_pend[g]++;
      exp_ptr = (g + 1) % N;
    end
    if (rfire && exp_pend[ri] > 0) exp_pend[ri]--;
    exp_vld = acc || (exp_vld && !req_ready_out);
    #1;
    chk("req_valid_out", 64'(req_valid_out), 64'(exp_vld));
    if (exp_vld && sbq.size() > 0) begin
      chk("req_rw_out", 64'(req_rw_out), 64'(sbq[0].rw));
      chk("req_byteen_out", 64'(req_byteen_out), 64'(sbq[0].byteen));
      chk("req_addr_out", 64'(req_addr_out), 64'(sbq[0].addr));
      chk("req_data_out", 64'(req_data_out), 64'(sbq[0].data));
      chk("req_tag_out", 64'(req_tag_out), 64'(sbq[0].tag));
    end
    chk("busy", 64'(busy), 64'(exp_vld || pend_any()));
  endtask

  task automatic drain();
    req_valid_in  = '0;
    rsp_ready_out = '1;
    for (int i = 0; i < N; i++) begin
      while (exp_pend[i] > 0) begin
        rsp_valid_in = 1'b1;
        rsp_tag_in   = {8'h00, 2'(i)};
        rsp_data_in  = $urandom;
        cycle();
      end
    end
    rsp_valid_in = 1'b0;
    rsp_tag_in   = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    req_valid_in  = '1;
    req_rw_in     = '0;
    req_byteen_in = '0;
    req_addr_in   = '0;
    req_data_in   = '0;
    req_tag_in    = '0;
    req_ready_out = 1'b1;
    rsp_valid_in  = 1'b0;
    rsp_data_in   = '0;
    rsp_tag_in    = '0;
    rsp_ready_out = '0;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_in", 64'(req_ready_in), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid_out", 64'(req_valid_out), 64'd0);
    reset        = 1'b0;
    req_valid_in = '0;

    // All requesters reading: strict rotation 0,1,2,3 and tag LSBs follow
    req_valid_in = 4'hF;
    req_rw_in    = 4'h0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("t1_grant", 64'(last_g), 64'(k % 4));
      chk("t1_tag_lsb", 64'(req_tag_out[1:0]), 64'(k % 4));
    end
    req_valid_in = '0;

    // Response routing for tag 0x2D
    rsp_valid_in  = 1'b1;
    rsp_tag_in    = 10'h2D;
    rsp_data_in   = 32'hCAFE0001;
    rsp_ready_out = 4'b0010;
    #1;
    chk("rsp_route_valid", 64'(rsp_valid_out), 64'h2);
    chk("rsp_route_tag1", 64'(rsp_tag_out[1]), 64'h0B);
    chk("rsp_route_data3", 64'(rsp_data_out[3]), 64'hCAFE0001);
    chk("rsp_route_ready_hi", 64'(rsp_ready_in), 64'd1);
    rsp_ready_out = 4'b1101;
    #1;
    chk("rsp_route_ready_lo", 64'(rsp_ready_in), 64'd0);
    rsp_ready_out = 4'b0010;
    cycle();
    rsp_valid_in = 1'b0;
    drain();
    cycle();
    chk("idle_busy", 64'(busy), 64'd0);

    // Requester 2 exhausts its credits, then resumes after one response
    req_valid_in = 4'b0100;
    req_rw_in    = 4'h0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      chk("t2_accept", 64'(obs_rin[2]), 64'd1);
    end
    cycle();
    chk("t2_hold17", 64'(obs_rin[2]), 64'd0);
    cycle();
    chk("t2_hold17b", 64'(obs_rin[2]), 64'd0);
    rsp_valid_in  = 1'b1;
    rsp_tag_in    = {8'hA5, 2'd2};
    rsp_ready_out = 4'b0100;
    cycle();
    chk("t2_hold_rsp", 64'(obs_rin[2]), 64'd0);
    rsp_valid_in = 1'b0;
    cycle();
    chk("t2_resume", 64'(obs_rin[2]), 64'd1);
    drain();

    // Requester 1 at full credit: write passes, read stays blocked
    req_valid_in = 4'b0010;
    req_rw_in    = 4'h0;
    repeat (16) cycle();
    req_rw_in = 4'b0010;
    cycle();
    chk("t3_write_acc", 64'(obs_rin[1]), 64'd1);
    req_rw_in = 4'h0;
    cycle();
    chk("t3_read_blocked", 64'(obs_rin[1]), 64'd0);
    req_valid_in = '0;

    // Memory side stalls for 5 cycles
    req_ready_out = 1'b0;
    req_valid_in  = 4'b1001;
    cycle();
    chk("t4_first_grant", 64'(last_g), 64'd3);
    snap = sbq[0];
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t4_stall_rin", 64'(obs_rin), 64'd0);
      chk("t4_stable_addr", 64'(req_addr_out), 64'(snap.addr));
      chk("t4_stable_tag", 64'(req_tag_out), 64'(snap.tag));
    end
    req_ready_out = 1'b1;
    cycle();
    n_acc = $countones(obs_rin);
    req_valid_in = '0;
    cycle();
    n_acc += $countones(obs_rin);
    chk("t4_one_accept", 64'(n_acc), 64'd1);
    drain();

    // Reset with reads pending and a write buffered
    req_ready_out = 1'b1;
    req_valid_in  = 4'b1000;
    req_rw_in     = 4'h0;
    repeat (3) cycle();
    req_valid_in = 4'b0010;
    req_rw_in    = 4'b0010;
    cycle();
    req_ready_out = 1'b0;
    req_valid_in  = '0;
    req_rw_in     = '0;
    cycle();
    chk("t5_buffered", 64'(req_valid_out), 64'd1);
    reset        = 1'b1;
    req_valid_in = 4'hF;
    #1;
    chk("t5_rst_rin", 64'(req_ready_in), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    chk("t5_valid_out", 64'(req_valid_out), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    req_ready_out = 1'b1;
    cycle();
    chk("t5_first_grant", 64'(obs_rin), 64'b0001);
    req_valid_in = '0;
    cycle();
    drain();
    cycle();
    chk("end_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_mem_credit_arb.md
VX_MEM_CREDIT_ARB -- requirements
Module: VX_mem_credit_arb

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of requesters (clusters), 1..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 512: request/response data width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 26: line address width.
REQ-004 SHALL have parameter TAG_IN_WIDTH, default 8: requester tag width.
REQ-005 SHALL have parameter MAX_PENDING, default 16: outstanding reads allowed per requester, 1..255.
REQ-006 SHALL derive LOG_REQS = clog2(NUM_REQS), which is 0 when NUM_REQS = 1, and TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_REQS.
REQ-007 SHALL have port clk, input, 1: the single clock.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have ports req_valid_in/req_rw_in, input, [NUM_REQS]; req_byteen_in [NUM_REQS][DATA_WIDTH/8], req_addr_in [NUM_REQS][ADDR_WIDTH], req_data_in [NUM_REQS][DATA_WIDTH] and req_tag_in [NUM_REQS][TAG_IN_WIDTH], all inputs, carrying the per-requester request.
REQ-010 SHALL have port req_ready_in, output, [NUM_REQS]: per-requester accept.
REQ-011 SHALL have outputs req_valid_out 1, req_rw_out 1, req_byteen_out, req_addr_out, req_data_out and req_tag_out [TAG_OUT_WIDTH], plus input req_ready_out 1, forming the memory-side request.
REQ-012 SHALL have inputs rsp_valid_in 1, rsp_data_in [DATA_WIDTH] and rsp_tag_in [TAG_OUT_WIDTH], plus output rsp_ready_in 1, forming the memory-side response.
REQ-013 SHALL have outputs rsp_valid_out [NUM_REQS], rsp_data_out [NUM_REQS][DATA_WIDTH] and rsp_tag_out [NUM_REQS][TAG_IN_WIDTH], plus input rsp_ready_out [NUM_REQS], forming the per-requester response.
REQ-014 SHALL have port busy, output, 1: any read outstanding or any request buffered.

Function
REQ-015 SHALL treat requester i as eligible when req_valid_in[i] && (req_rw_in[i] || pending[i] < MAX_PENDING); writes never consume credit.
REQ-016 SHALL grant the first eligible requester at or after rr_ptr, searching in ascending index order with wrap-around.
REQ-017 SHALL assert req_ready_in[i] only when i is granted and the output register is empty or req_ready_out = 1 (single-entry output register, 1-cycle latency, full throughput).
REQ-018 SHALL, on accept, load the output register with the granted fields and req_tag_out = {req_tag_in[i], i[LOG_REQS-1:0]}, and set rr_ptr = (i+1) mod NUM_REQS.
REQ-019 SHALL hold the output register stable while req_valid_out && !req_ready_out.
REQ-020 SHALL increment pending[i] when a read (rw = 0) is accepted from requester i.
REQ-021 SHALL route each response to idx = rsp_tag_in[LOG_REQS-1:0]: rsp_valid_out[idx] = rsp_valid_in, rsp_tag_out = rsp_tag_in >> LOG_REQS, rsp_ready_in = rsp_ready_out[idx]; this path is combinational, and data is broadcast to all requesters.
REQ-022 SHALL decrement pending[idx] on rsp_valid_in && rsp_ready_in.
REQ-023 SHALL leave pending unchanged when an increment and a decrement hit the same counter in the same cycle.
REQ-024 SHALL flag a response to a requester with pending = 0 with a simulation-only assertion; the counter SHALL saturate at 0.
REQ-025 SHALL, when NUM_REQS = 1, append no index bits and still register the request path.
REQ-026 SHALL drive busy = req_valid_out || (|pending).

Reset
REQ-027 SHALL, while reset is high at a clk edge, clear req_valid_out, every pending[i] and rr_ptr; busy and all req_ready_in SHALL be 0 during reset.
REQ-028 SHALL drop a request buffered in the output register at reset; reset mid-operation discards all credit state.

Configuration
REQ-029 SHALL, with VX_MEM_ARB_PERF_EN defined, add outputs perf_stall_cycles [64] and perf_reads [64]; without the macro these ports and their logic SHALL be absent.
REQ-030 SHALL count a stall cycle in perf_stall_cycles (reset 0) for each cycle with any req_valid_in set and no acceptance.
REQ-031 SHALL count accepted reads in perf_reads (reset 0); both counters SHALL wrap modulo 2^64.

Structure
REQ-032 SHALL place the request struct (rw, byteen, addr, data, tag) and the width-derivation functions in the shared package VX_mem_arb_pkg.
REQ-033 SHALL implement the grant search in the sub-module VX_rr_arbiter (inputs: eligible mask, advance enable; outputs: one-hot grant and index).

Verification
REQ-034 SHALL cover: all 4 requesters issue reads continuously, req_ready_out = 1 -> grants 0,1,2,3,0... and req_tag_out LSBs cycle 0..3.
REQ-035 SHALL cover: requester 2 issues 16 reads with no responses (MAX_PENDING = 16) -> 17th read held with req_ready_in[2] = 0, and it is accepted the cycle after one tag-2 response fires.
REQ-036 SHALL cover: requester 1 has pending = 16 and issues a write -> write accepted, pending stays 16.
REQ-037 SHALL cover: req_ready_out held 0 for 5 cycles -> output fields unchanged, all req_ready_in = 0, and exactly one acceptance after release.
REQ-038 SHALL cover: rsp_tag_in = 0x2D (NUM_REQS = 4) -> rsp_valid_out[1] = 1, rsp_tag_out = 0x0B, and rsp_ready_in follows rsp_ready_out[1].
REQ-039 SHALL cover: reset asserted with 3 reads pending and a request buffered -> next cycle req_valid_out = 0, busy = 0, grant starts at requester 0.
